dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter_pkg.sv | 20 ++
 rtl/dmem_arbiter_rd_return.sv | 66 ++++++
 rtl/dmem_arbiter.sv | 196 +++++++++++++++++++
 tb/tb_dmem_arbiter.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arbiter_pkg.sv
// Shared CPU package: data-memory geometry, arbiter state encoding and
// read-return owner tag, used by the datapath, decoder and dmem arbiter.
package dmem_arbiter_pkg;

  localparam int unsigned DMEM_ADDR_W = 10;
  localparam int unsigned DMEM_DATA_W = 19;

  typedef enum logic [1:0] {
    CPU_PRI   = 2'd0,
    EXT_LOCK  = 2'd1,
    CPU_FORCE = 2'd2
  } arb_state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_EXT  = 2'd2
  } rd_owner_t;

endpackage

// File: rtl/dmem_arbiter_rd_return.sv
// Load-return path: remembers which port issued the load and steers the
// synchronous memory output back to it one cycle later.
module dmem_rd_return
  import dmem_arbiter_pkg::*;
#(
  parameter int DATA_W = DMEM_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  rd_owner_t         load_owner,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              ext_rvalid,
  output logic [DATA_W-1:0] ext_rdata
);

  rd_owner_t         owner_r;
  logic [DATA_W-1:0] cpu_hold_r;
  logic [DATA_W-1:0] ext_hold_r;

  // owner tag of the load issued last cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_r <= OWN_NONE;
    end else begin
      owner_r <= load_owner;
    end
  end

  // capture returned words so each port keeps its last valid data
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cpu_hold_r <= '0;
      ext_hold_r <= '0;
    end else begin
      if (owner_r == OWN_CPU) begin
        cpu_hold_r <= mem_rdata;
      end else begin
        cpu_hold_r <= cpu_hold_r;
      end
      if (owner_r == OWN_EXT) begin
        ext_hold_r <= mem_rdata;
      end else begin
        ext_hold_r <= ext_hold_r;
      end
    end
  end

  // memory data passes straight through in its valid cycle
  always_comb begin
    cpu_rvalid = (owner_r == OWN_CPU);
    ext_rvalid = (owner_r == OWN_EXT);
    if (cpu_rvalid) begin
      cpu_rdata = mem_rdata;
    end else begin
      cpu_rdata = cpu_hold_r;
    end
    if (ext_rvalid) begin
      ext_rdata = mem_rdata;
    end else begin
      ext_rdata = ext_hold_r;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter between the CPU datapath and the loader/debug port:
// CPU priority with starvation relief, bounded ext lock bursts.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int ADDR_W     = DMEM_ADDR_W,
  parameter int DATA_W     = DMEM_DATA_W,
  parameter int STARVE_MAX = 4,
  parameter int LOCK_MAX   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_stall,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_rvalid,
  input  logic              ext_req,
  input  logic              ext_we,
  input  logic              ext_lock,
  input  logic [ADDR_W-1:0] ext_addr,
  input  logic [DATA_W-1:0] ext_wdata,
  output logic              ext_gnt,
  output logic [DATA_W-1:0] ext_rdata,
  output logic              ext_rvalid,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam int LW = $clog2(LOCK_MAX + 1);
  localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_MAX);
  localparam logic [LW-1:0] LOCK_TOP   = LW'(LOCK_MAX);

  arb_state_t        state_r;
  logic [SW-1:0]     starve_cnt_r;
  logic [LW-1:0]     lock_cnt_r;
  logic              cpu_gnt_s;
  logic              ext_gnt_s;
  logic [ADDR_W-1:0] addr_hold_r;
  logic [DATA_W-1:0] wdata_hold_r;
  rd_owner_t         load_owner_s;

  // grant decision; nothing is granted while reset is asserted
  always_comb begin
    cpu_gnt_s = 1'b0;
    ext_gnt_s = 1'b0;
    if (rst) begin
      cpu_gnt_s = 1'b0;
      ext_gnt_s = 1'b0;
    end else begin
      case (state_r)
        CPU_PRI: begin
          if (ext_req && (!cpu_req || (starve_cnt_r == STARVE_TOP))) begin
            ext_gnt_s = 1'b1;
          end else begin
            cpu_gnt_s = cpu_req;
          end
        end
        EXT_LOCK: begin
          if (ext_req) begin
            ext_gnt_s = 1'b1;
          end else begin
            cpu_gnt_s = cpu_req;
          end
        end
        CPU_FORCE: begin
          if (cpu_req) begin
            cpu_gnt_s = 1'b1;
          end else begin
            ext_gnt_s = ext_req;
          end
        end
        default: begin
          cpu_gnt_s = 1'b0;
          ext_gnt_s = 1'b0;
        end
      endcase
    end
  end

  // arbitration FSM and lock-burst length counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= CPU_PRI;
      lock_cnt_r <= '0;
    end else begin
      case (state_r)
        CPU_PRI: begin
          if (ext_gnt_s && ext_lock) begin
            state_r    <= (LOCK_TOP == LW'(1)) ? CPU_FORCE : EXT_LOCK;
            lock_cnt_r <= LW'(1);
          end else begin
            state_r    <= CPU_PRI;
            lock_cnt_r <= '0;
          end
        end
        EXT_LOCK: begin
          if (ext_gnt_s && ((lock_cnt_r + LW'(1)) == LOCK_TOP)) begin
            state_r    <= CPU_FORCE;
            lock_cnt_r <= '0;
          end else if (ext_gnt_s && ext_lock) begin
            state_r    <= EXT_LOCK;
            lock_cnt_r <= lock_cnt_r + LW'(1);
          end else begin
            state_r    <= CPU_PRI;
            lock_cnt_r <= '0;
          end
        end
        CPU_FORCE: begin
          state_r    <= CPU_PRI;
          lock_cnt_r <= '0;
        end
        default: begin
          state_r    <= CPU_PRI;
          lock_cnt_r <= '0;
        end
      endcase
    end
  end

  // count consecutive cycles the ext port asked and was refused
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt_r <= '0;
    end else if (ext_req && !ext_gnt_s) begin
      if (starve_cnt_r == STARVE_TOP) begin
        starve_cnt_r <= starve_cnt_r;
      end else begin
        starve_cnt_r <= starve_cnt_r + SW'(1);
      end
    end else begin
      starve_cnt_r <= '0;
    end
  end

  // keep the last granted address/data on the bus while idle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_hold_r  <= '0;
      wdata_hold_r <= '0;
    end else if (cpu_gnt_s) begin
      addr_hold_r  <= cpu_addr;
      wdata_hold_r <= cpu_wdata;
    end else if (ext_gnt_s) begin
      addr_hold_r  <= ext_addr;
      wdata_hold_r <= ext_wdata;
    end else begin
      addr_hold_r  <= addr_hold_r;
      wdata_hold_r <= wdata_hold_r;
    end
  end

  // memory port mux and load owner tag for the return path
  always_comb begin
    mem_we       = 1'b0;
    mem_addr     = addr_hold_r;
    mem_wdata    = wdata_hold_r;
    load_owner_s = OWN_NONE;
    if (cpu_gnt_s) begin
      mem_we       = cpu_we;
      mem_addr     = cpu_addr;
      mem_wdata    = cpu_wdata;
      load_owner_s = cpu_we ? OWN_NONE : OWN_CPU;
    end else if (ext_gnt_s) begin
      mem_we       = ext_we;
      mem_addr     = ext_addr;
      mem_wdata    = ext_wdata;
      load_owner_s = ext_we ? OWN_NONE : OWN_EXT;
    end else begin
      mem_we       = 1'b0;
      load_owner_s = OWN_NONE;
    end
  end

  assign cpu_stall = cpu_req & ~cpu_gnt_s;
  assign ext_gnt   = ext_gnt_s;

  dmem_rd_return #(
    .DATA_W(DATA_W)
  ) u_rd_return (
    .clk       (clk),
    .rst       (rst),
    .load_owner(load_owner_s),
    .mem_rdata (mem_rdata),
    .cpu_rvalid(cpu_rvalid),
    .cpu_rdata (cpu_rdata),
    .ext_rvalid(ext_rvalid),
    .ext_rdata (ext_rdata)
  );

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a synchronous-read memory model.
module tb_dmem_arbiter;

  logic        clk;
  logic        rst;
  logic        cpu_req, cpu_we;
  logic [9:0]  cpu_addr;
  logic [18:0] cpu_wdata;
  logic        cpu_stall, cpu_rvalid;
  logic [18:0] cpu_rdata;
  logic        ext_req, ext_we, ext_lock;
  logic [9:0]  ext_addr;
  logic [18:0] ext_wdata;
  logic        ext_gnt, ext_rvalid;
  logic [18:0] ext_rdata;
  logic        mem_we;
  logic [9:0]  mem_addr;
  logic [18:0] mem_wdata;
  logic [18:0] mem_rdata;

  logic [18:0] mem [0:1023];

  int n_total;
  int n_bad;

  dmem_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_stall (cpu_stall),
    .cpu_rdata (cpu_rdata),
    .cpu_rvalid(cpu_rvalid),
    .ext_req   (ext_req),
    .ext_we    (ext_we),
    .ext_lock  (ext_lock),
    .ext_addr  (ext_addr),
    .ext_wdata (ext_wdata),
    .ext_gnt   (ext_gnt),
    .ext_rdata (ext_rdata),
    .ext_rvalid(ext_rvalid),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // synchronous-read data memory
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // advance to just after the next rising edge and apply new requests
  task automatic drive(input logic cr, input logic cw, input logic [9:0] ca, input logic [18:0] cd,
                       input logic er, input logic ew, input logic el, input logic [9:0] ea,
                       input logic [18:0] ed);
    @(posedge clk);
    #1;
    cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
    ext_req = er; ext_we = ew; ext_lock = el; ext_addr = ea; ext_wdata = ed;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 10'h000, 19'h00000, 1'b0, 1'b0, 1'b0, 10'h000, 19'h00000);
    @(negedge clk);
  endtask

  initial begin
    n_total = 0;
    n_bad   = 0;
    rst = 1'b1;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 10'h000; cpu_wdata = 19'h00000;
    ext_req = 1'b0; ext_we = 1'b0; ext_lock = 1'b0; ext_addr = 10'h000; ext_wdata = 19'h00000;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_cpu_rvalid", {31'd0, cpu_rvalid}, 32'd0);
    check("rst_ext_rvalid", {31'd0, ext_rvalid}, 32'd0);
    check("rst_cpu_rdata", {13'd0, cpu_rdata}, 32'd0);
    check("rst_mem_addr", {22'd0, mem_addr}, 32'd0);
    check("rst_mem_wdata", {13'd0, mem_wdata}, 32'd0);
    check("rst_ext_gnt", {31'd0, ext_gnt}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // preload: mem[5] = 0x1ABCD, mem[7] = 0x02222
    drive(1'b1, 1'b1, 10'h005, 19'h1ABCD, 1'b0, 1'b0, 1'b0, 10'h000, 19'h00000);
    @(negedge clk);
    check("st_mem_we", {31'd0, mem_we}, 32'd1);
    check("st_mem_wdata", {13'd0, mem_wdata}, 32'h1ABCD);
    drive(1'b1, 1'b1, 10'h007, 19'h02222, 1'b0, 1'b0, 1'b0, 10'h000, 19'h00000);
    @(negedge clk);
    check("st_no_rvalid", {31'd0, cpu_rvalid}, 32'd0);

    // lone cpu load of address 5
    drive(1'b1, 1'b0, 10'h005, 19'h00000, 1'b0, 1'b0, 1'b0, 10'h000, 19'h00000);
    @(negedge clk);
    check("ld_mem_addr", {22'd0, mem_addr}, 32'h005);
    check("ld_mem_we", {31'd0, mem_we}, 32'd0);
    check("ld_stall", {31'd0, cpu_stall}, 32'd0);
    check("st2_no_rvalid", {31'd0, cpu_rvalid}, 32'd0);
    idle();
    check("ld_rvalid", {31'd0, cpu_rvalid}, 32'd1);
    check("ld_rdata", {13'd0, cpu_rdata}, 32'h1ABCD);
    check("ld_ext_rvalid", {31'd0, ext_rvalid}, 32'd0);
    check("idle_hold_addr", {22'd0, mem_addr}, 32'h005);
    idle();
    check("ld_rvalid_drop", {31'd0, cpu_rvalid}, 32'd0);
    check("ld_rdata_hold", {13'd0, cpu_rdata}, 32'h1ABCD);

    // store then load of the same address returns the new data
    drive(1'b1, 1'b1, 10'h009, 19'h12345, 1'b0, 1'b0, 1'b0, 10'h000, 19'h00000);
    @(negedge clk);
    drive(1'b1, 1'b0, 10'h009, 19'h00000, 1'b0, 1'b0, 1'b0, 10'h000, 19'h00000);
    @(negedge clk);
    idle();
    check("raw_rdata", {13'd0, cpu_rdata}, 32'h12345);

    // contention without lock: ext wins only once starved for 4 cycles
    for (int i = 1; i <= 6; i++) begin
      drive(1'b1, 1'b1, 10'h040 + 10'(i), 19'(i), 1'b1, 1'b1, 1'b0, 10'h080 + 10'(i), 19'(i));
      @(negedge clk);
      check($sformatf("pri_ext_gnt_c%0d", i), {31'd0, ext_gnt}, (i == 5) ? 32'd1 : 32'd0);
      check($sformatf("pri_stall_c%0d", i), {31'd0, cpu_stall}, (i == 5) ? 32'd1 : 32'd0);
      check($sformatf("pri_addr_c%0d", i), {22'd0, mem_addr},
            (i == 5) ? (32'h080 + 32'(i)) : (32'h040 + 32'(i)));
    end
    idle();

    // locked ext store burst: cpu wants the bus from cycle 2 to 9
    for (int c = 1; c <= 11; c++) begin
      drive((c >= 2) && (c <= 9), 1'b1, 10'h200, 19'(c), 1'b1, 1'b1, 1'b1, 10'h100 + 10'(c), 19'(c));
      @(negedge clk);
      check($sformatf("lock_ext_gnt_c%0d", c), {31'd0, ext_gnt}, (c != 9) ? 32'd1 : 32'd0);
      check($sformatf("lock_stall_c%0d", c), {31'd0, cpu_stall},
            ((c >= 2) && (c <= 8)) ? 32'd1 : 32'd0);
      check($sformatf("lock_addr_c%0d", c), {22'd0, mem_addr},
            (c == 9) ? 32'h200 : (32'h100 + 32'(c)));
    end
    idle();

    // alternating cpu/ext loads: data returns on the issuing port only
    drive(1'b1, 1'b0, 10'h005, 19'h00000, 1'b0, 1'b0, 1'b0, 10'h000, 19'h00000);
    @(negedge clk);
    drive(1'b0, 1'b0, 10'h000, 19'h00000, 1'b1, 1'b0, 1'b0, 10'h007, 19'h00000);
    @(negedge clk);
    check("alt1_cpu_rvalid", {31'd0, cpu_rvalid}, 32'd1);
    check("alt1_cpu_rdata", {13'd0, cpu_rdata}, 32'h1ABCD);
    check("alt1_ext_rvalid", {31'd0, ext_rvalid}, 32'd0);
    drive(1'b1, 1'b0, 10'h007, 19'h00000, 1'b0, 1'b0, 1'b0, 10'h000, 19'h00000);
    @(negedge clk);
    check("alt2_ext_rvalid", {31'd0, ext_rvalid}, 32'd1);
    check("alt2_ext_rdata", {13'd0, ext_rdata}, 32'h02222);
    check("alt2_cpu_rvalid", {31'd0, cpu_rvalid}, 32'd0);
    drive(1'b0, 1'b0, 10'h000, 19'h00000, 1'b1, 1'b0, 1'b0, 10'h005, 19'h00000);
    @(negedge clk);
    check("alt3_cpu_rvalid", {31'd0, cpu_rvalid}, 32'd1);
    check("alt3_cpu_rdata", {13'd0, cpu_rdata}, 32'h02222);
    check("alt3_ext_rvalid", {31'd0, ext_rvalid}, 32'd0);
    idle();
    check("alt4_ext_rvalid", {31'd0, ext_rvalid}, 32'd1);
    check("alt4_ext_rdata", {13'd0, ext_rdata}, 32'h1ABCD);
    check("alt4_cpu_rvalid", {31'd0, cpu_rvalid}, 32'd0);
    idle();
    check("alt5_ext_rvalid", {31'd0, ext_rvalid}, 32'd0);
    check("alt5_ext_hold", {13'd0, ext_rdata}, 32'h1ABCD);

    // reset during a locked burst with an ext load outstanding
    drive(1'b0, 1'b0, 10'h000, 19'h00000, 1'b1, 1'b0, 1'b1, 10'h005, 19'h00000);
    @(negedge clk);
    check("rl_ext_gnt0", {31'd0, ext_gnt}, 32'd1);
    drive(1'b0, 1'b0, 10'h000, 19'h00000, 1'b1, 1'b0, 1'b1, 10'h007, 19'h00000);
    @(negedge clk);
    check("rl_ext_gnt1", {31'd0, ext_gnt}, 32'd1);
    check("rl_ext_rvalid0", {31'd0, ext_rvalid}, 32'd1);
    #2;
    rst = 1'b1;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 10'h300; cpu_wdata = 19'h00055;
    #1;
    check("rl_rst_ext_rvalid", {31'd0, ext_rvalid}, 32'd0);
    check("rl_rst_ext_rdata", {13'd0, ext_rdata}, 32'd0);
    check("rl_rst_ext_gnt", {31'd0, ext_gnt}, 32'd0);
    check("rl_rst_mem_we", {31'd0, mem_we}, 32'd0);
    @(posedge clk);
    #1;
    check("rl_rst_ext_rvalid2", {31'd0, ext_rvalid}, 32'd0);
    rst = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'h005;
    ext_req = 1'b1; ext_we = 1'b0; ext_lock = 1'b1; ext_addr = 10'h007;
    @(negedge clk);
    check("rl_post_stall", {31'd0, cpu_stall}, 32'd0);
    check("rl_post_ext_gnt", {31'd0, ext_gnt}, 32'd0);
    check("rl_post_addr", {22'd0, mem_addr}, 32'h005);
    idle();
    check("rl_post_cpu_rvalid", {31'd0, cpu_rvalid}, 32'd1);
    check("rl_post_cpu_rdata", {13'd0, cpu_rdata}, 32'h1ABCD);
    check("rl_post_ext_rvalid", {31'd0, ext_rvalid}, 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
